board_disassembler: RTL and testbench
=====================================

# board_disassembler

Receive-side decoder for the PC link protocol. Consumes the byte stream from the UART receiver and rebuilds 16-bit messages, sent low byte first, of the form {flag[2:0], index[11:0], value}. It decodes the START_BOARD, AND and END_BOARD sequence into a row-major solution bit-vector plus board dimensions m and n. It mirrors the transmit-side assembler so a board can be loaded from the PC, or looped back for self-test.

## Interface
- MAX_ROWS, 11, maximum board rows.
- MAX_COLS, 11, maximum board columns.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- valid_in  in  1  one-cycle strobe; byte_in valid this cycle.
- byte_in  in  8  received byte.
- solution  out  MAX_ROWS*MAX_COLS  cell (r,c) at bit r*MAX_COLS+c.
- m  out  $clog2(MAX_ROWS)  rows of last/current board.
- n  out  $clog2(MAX_COLS)  columns of last/current board.
- valid_out  out  1  one-cycle pulse: board complete.
- error  out  1  one-cycle pulse: protocol violation.

## Operation
- Flags: START_BOARD=3'b111, AND=3'b101, END_BOARD=3'b000; any other flag is illegal.
- Byte phase bit: the low byte is stored in a register. On the high byte, msg={byte_in, lo_reg}, which is decoded in that same cycle. The phase toggles per accepted byte.
- States and transitions:
  - IDLE: START carrying index k → m<=k, solution<=0, count/row/col<=0, go GET_N. AND or END → error, stay IDLE.
  - GET_N: START carrying k → n<=k, go ASSIGN. Any other flag → error, go IDLE.
  - ASSIGN, AND: write value to solution[row*MAX_COLS+col]. Advance col; when col wraps past n-1, col<=0 and row++. count++. After cell m*n-1, go FULL.
  - ASSIGN, START: resync. Treat as a new m and behave exactly as IDLE-START.
  - ASSIGN, END: error, go IDLE.
  - FULL, END: valid_out pulse, go IDLE.
  - FULL, AND: error, go IDLE.
  - FULL, START: treat as a new m and behave exactly as IDLE-START.
- Dimension check: m==0, m>MAX_ROWS, n==0 or n>MAX_COLS → error, go IDLE.
- Address arithmetic: row*MAX_COLS+col uses incremental counters, not a multiplier. Widths are $clog2(MAX_ROWS*MAX_COLS).
- On every error, the phase bit resets to low-byte.
- Outputs hold: solution, m and n hold after valid_out until the next accepted START(m). Cells never written read 0.

## Timing
- Reset values: solution=0, m=0, n=0, valid_out=0, error=0, state=IDLE, phase=low.
- valid_out and error are registered. Each is high for the single cycle after the clock edge that samples the offending or terminating high byte.
- A solution bit updates at the edge sampling the AND high byte, so it is visible one cycle later.
- Back-to-back valid_in on consecutive cycles is supported. Gaps of any length are allowed between bytes.
- rst mid-message discards the partial byte pair and the partial board.

## Configuration
- BOARD_DISASSEMBLER_INDEX_CHECK_EN defined:
  - In ASSIGN, an AND whose index field ≠ count raises error and goes IDLE, with no write.
- BOARD_DISASSEMBLER_INDEX_CHECK_EN undefined:
  - The index field is ignored. Writes use the internal counters only.
  - An out-of-sequence index never raises error.
  - All other errors remain.

## Test plan
- Full 3x2 board: bytes 06 E0, 04 E0, then AND for idx 0..5 with values 1,0,0,1,0,1 (01 A0, 02 A0, 04 A0, 07 A0, 08 A0, 0B A0), then 00 00 → one valid_out pulse; m=3, n=2; solution bits 0, 12 and 23 set, all others 0; error never asserted.
- Early END: START m=2, START n=2, two ANDs, then 00 00 → error pulse; no valid_out; state IDLE. The next full board decodes correctly.
- Illegal flag: msg 0x6000 (bytes 00 60) in GET_N → error. A following valid START/START/AND…/END → valid_out.
- Oversize dimension: START m=12 (bytes 18 E0) → error, IDLE; m unchanged.
- With BOARD_DISASSEMBLER_INDEX_CHECK_EN, a 2x2 board sends idx 0 then idx 2 (05 A0) → error on the second AND; solution bit 1 stays 0. Without the macro, the same stream writes bit 1 and no error pulse occurs.
- Reset after a lone low byte 06, then a full 1x1 board (02 E0, 02 E0, 01 A0, 00 00) → valid_out; solution bit 0 = 1.

Source files
------------

// File: rtl/board_disassembler.sv
// board_disassembler: receive-side decoder for the PC link protocol.
// Rebuilds 16-bit messages {flag[2:0], index[11:0], value} from a byte
// stream (low byte first). It decodes START_BOARD / AND / END_BOARD
// sequences into a row-major solution vector plus board dimensions m, n.
// Optional feature: define BOARD_DISASSEMBLER_INDEX_CHECK_EN to reject
// AND messages whose index field does not match the running cell count.
module board_disassembler #(
  parameter int MAX_ROWS = 11,
  parameter int MAX_COLS = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [7:0]                   byte_in,
  output logic [MAX_ROWS*MAX_COLS-1:0] solution,
  output logic [$clog2(MAX_ROWS)-1:0]  m,
  output logic [$clog2(MAX_COLS)-1:0]  n,
  output logic                         valid_out,
  output logic                         error
);

  localparam int CELLS = MAX_ROWS * MAX_COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(MAX_ROWS);
  localparam int CW    = $clog2(MAX_COLS);

  localparam logic [2:0]  FLAG_START = 3'b111;
  localparam logic [2:0]  FLAG_AND   = 3'b101;
  localparam logic [11:0] ROWS_LIM   = 12'(MAX_ROWS);
  localparam logic [11:0] COLS_LIM   = 12'(MAX_COLS);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(MAX_COLS);

  typedef enum logic [1:0] {IDLE, GET_N, ASSIGN, FULL} state_t;

  state_t        state;
  logic          phase;      // 0: expecting low byte, 1: expecting high byte
  logic [7:0]    lo_reg;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] row_base;   // row*MAX_COLS, kept incrementally
`ifdef BOARD_DISASSEMBLER_INDEX_CHECK_EN
  logic [AW-1:0] count;
`endif

  logic [15:0]   msg;
  logic [2:0]    flag;
  logic [11:0]   idx;
  logic          val;
  logic          m_ok;
  logic          n_ok;
  logic          idx_ok;
  logic          last_cell;
  logic          col_last;
  logic [AW-1:0] addr;

  // The high byte is decoded in the same cycle it arrives.
  assign msg       = {byte_in, lo_reg};
  assign flag      = msg[15:13];
  assign idx       = msg[12:1];
  assign val       = msg[0];
  assign m_ok      = (idx != 12'd0) && (idx <= ROWS_LIM);
  assign n_ok      = (idx != 12'd0) && (idx <= COLS_LIM);
  assign col_last  = (col == n - 1'b1);
  assign last_cell = col_last && (row == m - 1'b1);
  assign addr      = row_base + AW'(col);

`ifdef BOARD_DISASSEMBLER_INDEX_CHECK_EN
  assign idx_ok = (idx == 12'(count));
`else
  assign idx_ok = 1'b1;
`endif

  // Byte pairing, protocol FSM and board storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      lo_reg    <= '0;
      row       <= '0;
      col       <= '0;
      row_base  <= '0;
`ifdef BOARD_DISASSEMBLER_INDEX_CHECK_EN
      count     <= '0;
`endif
      solution  <= '0;
      m         <= '0;
      n         <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error     <= 1'b0;
      if (valid_in) begin
        if (!phase) begin
          lo_reg <= byte_in;
          phase  <= 1'b1;
        end else begin
          // Every high byte completes a message, so phase returns to low,
          // which also covers the reset-to-low-byte rule on errors.
          phase <= 1'b0;
          if (state == GET_N) begin
            if (flag == FLAG_START && n_ok) begin
              n     <= CW'(idx);
              state <= ASSIGN;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end else if (flag == FLAG_START) begin
            // START outside GET_N always begins a new board (resync).
            if (m_ok) begin
              m        <= RW'(idx);
              solution <= '0;
              row      <= '0;
              col      <= '0;
              row_base <= '0;
`ifdef BOARD_DISASSEMBLER_INDEX_CHECK_EN
              count    <= '0;
`endif
              state    <= GET_N;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end else if (state == ASSIGN && flag == FLAG_AND && idx_ok) begin
            solution[addr] <= val;
            if (col_last) begin
              col      <= '0;
              row      <= row + 1'b1;
              row_base <= row_base + ROW_STRIDE;
            end else begin
              col <= col + 1'b1;
            end
`ifdef BOARD_DISASSEMBLER_INDEX_CHECK_EN
            count <= count + 1'b1;
`endif
            if (last_cell) state <= FULL;
          end else if (state == FULL && flag == 3'b000) begin
            valid_out <= 1'b1;
            state     <= IDLE;
          end else begin
            error <= 1'b1;
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_board_disassembler.sv
// Scoreboard bench for board_disassembler: stimulus pushes the expected
// valid_out/error event, a monitor pops and compares on each output pulse.
module tb_board_disassembler;

  localparam int CELLS = 121;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [7:0]       byte_in;
  logic [CELLS-1:0] solution;
  logic [3:0]       m;
  logic [3:0]       n;
  logic             valid_out;
  logic             error;

  typedef struct {
    logic             is_err;
    logic [CELLS-1:0] sol;
    logic [3:0]       m;
    logic [3:0]       n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  board_disassembler #(.MAX_ROWS(11), .MAX_COLS(11)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .byte_in(byte_in),
    .solution(solution), .m(m), .n(n), .valid_out(valid_out), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [CELLS-1:0] bits3(input int a, input int b, input int c);
    logic [CELLS-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic push_valid(input logic [CELLS-1:0] s, input logic [3:0] em, input logic [3:0] en);
    exp_t e;
    e.is_err = 1'b0; e.sol = s; e.m = em; e.n = en;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.sol = '0; e.m = '0; e.n = '0;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid_in = 1'b1;
    byte_in  = b;
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (valid_out || error)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {valid_out, error}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {valid_out, error}, e.is_err ? 2'b01 : 2'b10);
          if (!e.is_err) begin
            check("board_solution", solution, e.sol);
            check("board_m", m, e.m);
            check("board_n", n, e.n);
          end
        end
      end
    end
  end

  task automatic board_3x2();
    send(8'h06); send(8'hE0); send(8'h04); send(8'hE0);
    send(8'h01); send(8'hA0); send(8'h02); send(8'hA0);
    send(8'h04); send(8'hA0); send(8'h07); send(8'hA0);
    send(8'h08); send(8'hA0); send(8'h0B); send(8'hA0);
    push_valid(bits3(0, 12, 23), 4'd3, 4'd2);
    send(8'h00); send(8'h00);
    gap(2);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_solution", solution, '0);
    check("rst_m", m, 4'd0);
    check("rst_n", n, 4'd0);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_error", error, 1'b0);

    // Full 3x2 board, back-to-back bytes.
    board_3x2();

    // Early END after two cells, then a full board with gaps between bytes.
    send(8'h04); send(8'hE0); send(8'h04); send(8'hE0);
    send(8'h01); send(8'hA0); send(8'h03); send(8'hA0);
    push_err();
    send(8'h00); send(8'h00);
    gap(3);
    board_3x2();

    // Illegal flag in GET_N, then a 2x2 board with values 0,1,1,0.
    send(8'h04); send(8'hE0);
    push_err();
    send(8'h00); send(8'h60);
    gap(1);
    send(8'h04); send(8'hE0); send(8'h04); send(8'hE0);
    send(8'h00); send(8'hA0); gap(2);
    send(8'h03); send(8'hA0); send(8'h05); send(8'hA0);
    send(8'h06); send(8'hA0);
    push_valid(bits3(1, 11, -1), 4'd2, 4'd2);
    send(8'h00); send(8'h00);
    gap(2);

    // Oversize row count leaves the previous board intact.
    push_err();
    send(8'h18); send(8'hE0);
    gap(3);
    check("oversize_m_hold", m, 4'd2);
    check("oversize_n_hold", n, 4'd2);
    check("oversize_sol_hold", solution, bits3(1, 11, -1));

    // AND while idle, and a zero column count.
    push_err();
    send(8'h01); send(8'hA0);
    gap(1);
    send(8'h02); send(8'hE0);
    push_err();
    send(8'h00); send(8'hE0);
    gap(2);

    // Out-of-sequence index on the second AND of a 2x2 board.
    send(8'h04); send(8'hE0); send(8'h04); send(8'hE0);
    send(8'h01); send(8'hA0);
`ifdef BOARD_DISASSEMBLER_INDEX_CHECK_EN
    push_err();
    send(8'h05); send(8'hA0);
    gap(3);
    check("idxchk_bit1_clear", solution, bits3(0, -1, -1));
`else
    send(8'h05); send(8'hA0);
    gap(2);
    check("noidx_bit1_set", solution, bits3(0, 1, -1));
    send(8'h04); send(8'hA0); send(8'h07); send(8'hA0);
    push_valid(bits3(0, 1, 12), 4'd2, 4'd2);
    send(8'h00); send(8'h00);
    gap(2);
`endif

    // Reset after a lone low byte, then a 1x1 board.
    send(8'h06);
    gap(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m", m, 4'd0);
    check("midrst_solution", solution, '0);
    send(8'h02); send(8'hE0); send(8'h02); send(8'hE0);
    send(8'h01); send(8'hA0);
    push_valid(bits3(0, -1, -1), 4'd1, 4'd1);
    send(8'h00); send(8'h00);
    gap(10);

    check("all_expected_seen", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
